layer_arbiter: RTL and testbench

//   Registered round-robin arbiter sharing the RGB display output between three pixel-layer sources.

---
 rtl/layer_arbiter.sv | 124 ++++++++++++
 tb/tb_layer_arbiter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/layer_arbiter.sv
// Round-robin arbiter that shares the RGB display output between three pixel layers.
// Grants are held for a minimum of HOLD_CYCLES, and the granted source's colour is registered onto red/green/blue.
module layer_arbiter #(
    parameter int unsigned  HOLD_CYCLES = 4,
    parameter logic [23:0]  BG_COLOR    = 24'h000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RqFLag0,
    input  logic       RqFLag1,
    input  logic       RqFLag2,
    input  logic [7:0] r0,
    input  logic [7:0] g0,
    input  logic [7:0] b0,
    input  logic [7:0] r1,
    input  logic [7:0] g1,
    input  logic [7:0] b1,
    input  logic [7:0] r2,
    input  logic [7:0] g2,
    input  logic [7:0] b2,
    output logic [2:0] gnt,
    output logic       busy,
    output logic [7:0] red,
    output logic [7:0] green,
    output logic [7:0] blue
);

    generate
        if (HOLD_CYCLES == 0 || HOLD_CYCLES > 255) begin : g_bad_hold
            $error("layer_arbiter: HOLD_CYCLES must be in 1..255");
        end
    endgenerate

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, LOCK, OPEN} state_t;

    state_t     state, state_n;
    logic [7:0] cnt, cnt_n;
    logic [1:0] last, last_n;
    logic [2:0] gnt_n;
    logic [2:0] req;
    logic [1:0] pick;
    logic       decide;
    logic       do_grant;

    assign req = {RqFLag2, RqFLag1, RqFLag0};

    // Search order last+1, last+2, last: the current owner is always tried last.
    always_comb begin
        pick = last;
        case (last)
            2'd0:    pick = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
            2'd1:    pick = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
            default: pick = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
        endcase
    end

    // The last LOCK cycle applies the OPEN rules at the same edge, so a grant spans exactly HOLD_CYCLES before it can move.
    assign decide = (state == OPEN) || ((state == LOCK) && (cnt == HOLD_LAST));

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        last_n   = last;
        gnt_n    = gnt;
        do_grant = 1'b0;

        case (state)
            IDLE:    do_grant = |req;
            LOCK:    if (cnt != HOLD_LAST) cnt_n = cnt + 8'd1;
            default: ;
        endcase

        if (decide) begin
            if (req == 3'b000) begin
                state_n = IDLE;
                gnt_n   = '0;
            end else if (req == gnt) begin
                state_n = OPEN;
            end else begin
                do_grant = 1'b1;
            end
        end

        if (do_grant) begin
            gnt_n   = 3'b001 << pick;
            last_n  = pick;
            cnt_n   = '0;
            state_n = LOCK;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            last  <= 2'd2;
            gnt   <= '0;
            busy  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            last  <= last_n;
            gnt   <= gnt_n;
            busy  <= |gnt_n;
        end
    end

    // Colour follows the registered grant, one cycle behind it.
    always_ff @(posedge clk) begin
        if (rst) begin
            {red, green, blue} <= BG_COLOR;
        end else begin
            case (gnt)
                3'b001:  {red, green, blue} <= {r0, g0, b0};
                3'b010:  {red, green, blue} <= {r1, g1, b1};
                3'b100:  {red, green, blue} <= {r2, g2, b2};
                default: {red, green, blue} <= BG_COLOR;
            endcase
        end
    end

endmodule

// File: tb/tb_layer_arbiter.sv
// Bench for layer_arbiter: two instances (HOLD 4 and HOLD 1) driven by shared stimulus,
// each compared every cycle against an owner/age reference model.
module tb_layer_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] flag;
    logic [7:0] col_r [3];
    logic [7:0] col_g [3];
    logic [7:0] col_b [3];

    logic [2:0] gnt_a, gnt_b;
    logic       busy_a, busy_b;
    logic [7:0] red_a, green_a, blue_a, red_b, green_b, blue_b;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    layer_arbiter #(.HOLD_CYCLES(4), .BG_COLOR(24'h000000)) dut_a (
        .clk(clk), .rst(rst),
        .RqFLag0(flag[0]), .RqFLag1(flag[1]), .RqFLag2(flag[2]),
        .r0(col_r[0]), .g0(col_g[0]), .b0(col_b[0]),
        .r1(col_r[1]), .g1(col_g[1]), .b1(col_b[1]),
        .r2(col_r[2]), .g2(col_g[2]), .b2(col_b[2]),
        .gnt(gnt_a), .busy(busy_a), .red(red_a), .green(green_a), .blue(blue_a)
    );

    layer_arbiter #(.HOLD_CYCLES(1), .BG_COLOR(24'h123456)) dut_b (
        .clk(clk), .rst(rst),
        .RqFLag0(flag[0]), .RqFLag1(flag[1]), .RqFLag2(flag[2]),
        .r0(col_r[0]), .g0(col_g[0]), .b0(col_b[0]),
        .r1(col_r[1]), .g1(col_g[1]), .b1(col_b[1]),
        .r2(col_r[2]), .g2(col_g[2]), .b2(col_b[2]),
        .gnt(gnt_b), .busy(busy_b), .red(red_b), .green(green_b), .blue(blue_b)
    );

    // Reference model: owner (-1 = none), age = cycles the grant has been visible.
    int          m_hold [2] = '{4, 1};
    logic [23:0] m_bg   [2] = '{24'h000000, 24'h123456};
    int          m_own  [2];
    int          m_age  [2];
    int          m_last [2];
    logic [23:0] m_rgb  [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int rr_pick(input logic [2:0] req, input int last);
        for (int k = 1; k <= 3; k++) begin
            int c = (last + k) % 3;
            if (req[c]) return c;
        end
        return last;
    endfunction

    task automatic model_edge(input int i);
        if (rst) begin
            m_rgb[i]  = m_bg[i];
            m_own[i]  = -1;
            m_age[i]  = 0;
            m_last[i] = 2;
        end else begin
            m_rgb[i] = (m_own[i] < 0) ? m_bg[i]
                     : {col_r[m_own[i]], col_g[m_own[i]], col_b[m_own[i]]};
            if (m_own[i] < 0) begin
                if (flag != 3'b000) begin
                    m_own[i]  = rr_pick(flag, m_last[i]);
                    m_last[i] = m_own[i];
                    m_age[i]  = 1;
                end
            end else if (m_age[i] < m_hold[i]) begin
                m_age[i]++;
            end else if (flag == 3'b000) begin
                m_own[i] = -1;
            end else if (flag != (3'b001 << m_own[i])) begin
                m_own[i]  = rr_pick(flag, m_last[i]);
                m_last[i] = m_own[i];
                m_age[i]  = 1;
            end
        end
    endtask

    function automatic logic [2:0] exp_gnt(input int i);
        return (m_own[i] < 0) ? 3'b000 : 3'(3'b001 << m_own[i]);
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
        check("gnt_a", 32'(gnt_a), 32'(exp_gnt(0)));
        check("busy_a", 32'(busy_a), 32'(m_own[0] >= 0));
        check("rgb_a", 32'({red_a, green_a, blue_a}), 32'(m_rgb[0]));
        check("gnt_b", 32'(gnt_b), 32'(exp_gnt(1)));
        check("busy_b", 32'(busy_b), 32'(m_own[1] >= 0));
        check("rgb_b", 32'({red_b, green_b, blue_b}), 32'(m_rgb[1]));
        check("onehot_a", 32'($onehot0(gnt_a)), 32'd1);
        check("onehot_b", 32'($onehot0(gnt_b)), 32'd1);
    endtask

    task automatic rand_colours();
        for (int s = 0; s < 3; s++) begin
            col_r[s] = 8'($urandom);
            col_g[s] = 8'($urandom);
            col_b[s] = 8'($urandom);
        end
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        m_own  = '{-1, -1};
        m_age  = '{0, 0};
        m_last = '{2, 2};
        m_rgb  = '{24'h0, 24'h0};
        rand_colours();

        // Reset with every request raised, then all three held high.
        rst  = 1'b1;
        flag = 3'b111;
        run(2);
        check("reset_gnt", 32'(gnt_a), 32'h0);
        check("reset_rgb", 32'({red_a, green_a, blue_a}), 32'h0);
        rst = 1'b0;
        step();
        check("first_grant", 32'(gnt_a), 32'h1);
        run(14);

        // Single-cycle pulse on source 0 from idle.
        rst = 1'b1; flag = 3'b000; step();
        rst = 1'b0; flag = 3'b001; step();
        flag = 3'b000;
        run(7);

        // Source 1 alone with a fixed colour.
        col_r[1] = 8'hAA; col_g[1] = 8'h55; col_b[1] = 8'h0F;
        flag = 3'b010;
        run(10);
        check("src1_gnt", 32'(gnt_a), 32'h2);
        check("src1_rgb", 32'({red_a, green_a, blue_a}), 32'hAA550F);

        // Sources 0 and 2 competing.
        flag = 3'b101;
        run(8);

        // Reset while source 1 holds a locked grant, then restart with all requests.
        flag = 3'b000; run(6);
        flag = 3'b010; run(2);
        check("lock_gnt", 32'(gnt_a), 32'h2);
        rst = 1'b1; step();
        rst = 1'b0; flag = 3'b111;
        run(6);

        // Random traffic with occasional reset.
        for (int k = 0; k < 600; k++) begin
            flag = 3'($urandom);
            if ($urandom_range(0, 3) == 0) flag = 3'b000;
            rst = ($urandom_range(0, 49) == 0);
            rand_colours();
            step();
            if ($urandom_range(0, 1) == 0) begin
                rst = 1'b0;
                step();
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
